// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard/sequencing unit.
//  - mulState_t : multiply sequencer states (ST_IDLE / ST_BUSY)
//  - FWD_RF / FWD_W / FWD_M : forwarding select encodings
//  - REG_PC     : register number of the PC (never forwarded)
//  - fwdSel     : forwarding select for one Execute source operand
package hazard_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mulState_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [3:0] REG_PC = 4'd15;

  // Memory stage result is younger than Writeback, so it wins when both match.
  function automatic logic [1:0] fwdSel(input logic       regWriteM,
                                        input logic [3:0] wa3M,
                                        input logic       regWriteW,
                                        input logic [3:0] wa3W,
                                        input logic [3:0] ra);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ra != REG_PC) begin
      if (regWriteM && (wa3M == ra))      sel = FWD_M;
      else if (regWriteW && (wa3W == ra)) sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard unit.
//  master : pipeline side - drives register numbers / stage flags,
//           receives forward selects, stalls, flushes, multiplier control
//           and perf counters.
//  slave  : hazard unit side (directions reversed).
//  CNT_W  : width of StallCount / FlushCount.
interface hazard_ctrl_if #(parameter int CNT_W = 16);

  logic [3:0]       RA1D, RA2D, RA1E, RA2E;
  logic [3:0]       WA3E, WA3M, WA3W;
  logic             RegWriteM, RegWriteW, MemToRegE;
  logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic             BranchTakenE, LongE, CondExE;

  logic [1:0]       ForwardAE, ForwardBE;
  logic             StallF, StallD, StallE;
  logic             FlushD, FlushE, FlushM;
  logic             MulStart, MulBusy;
  logic [CNT_W-1:0] StallCount, FlushCount;

  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemToRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW,
           BranchTakenE, LongE, CondExE,
    input  ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MulStart, MulBusy,
           StallCount, FlushCount
  );

  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
           RegWriteM, RegWriteW, MemToRegE,
           PCSrcD, PCSrcE, PCSrcM, PCSrcW,
           BranchTakenE, LongE, CondExE,
    output ForwardAE, ForwardBE, StallF, StallD, StallE,
           FlushD, FlushE, FlushM, MulStart, MulBusy,
           StallCount, FlushCount
  );

endinterface

// File: rtl/hazard_ctrl_mul_seq.sv
// Multiply sequencer (mul_seq): holds Execute while the shared iterative
// multiplier runs.
//  clk, reset (async, active-low)
//  mulReq   : long multiply in Execute whose condition passed
//  mulStall : hold Execute / bubble into Memory
//  mulStart : one-cycle start pulse to the multiplier
//  mulBusy  : sequencing in progress (BUSY state)
// The stall is MUL_CYCLES cycles long: the request cycle itself plus
// MUL_CYCLES-1 BUSY cycles; the final BUSY cycle releases Execute, so the
// instruction sits in Execute for MUL_CYCLES+1 cycles.
module hazard_ctrl_mul_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mulReq,
  output logic mulStall,
  output logic mulStart,
  output logic mulBusy
);

  localparam logic [3:0] CNT_INIT = 4'(MUL_CYCLES - 1);

  mulState_t  state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mulReq) begin
            state <= ST_BUSY;
            cnt   <= CNT_INIT;
          end
        end
        ST_BUSY: begin
          if (cnt != 4'd0) cnt   <= cnt - 4'd1;
          else             state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A request seen while BUSY belongs to the instruction already being
  // sequenced, so it only starts from IDLE.
  assign mulStart = (state == ST_IDLE) && mulReq;
  assign mulStall = mulStart || ((state == ST_BUSY) && (cnt != 4'd0));
  assign mulBusy  = (state == ST_BUSY);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing unit for the 5-stage core.
//  clk   : core clock, rising edge
//  reset : asynchronous, active-low
//  hz    : hazard_ctrl_if.slave - register numbers and stage flags in;
//          ForwardAE/BE, StallF/D/E, FlushD/E/M, MulStart, MulBusy,
//          StallCount, FlushCount out.
// Forwarding, stalls and flushes are combinational; only the multiply
// sequencer and the perf counters hold state.
// Optional feature: define HAZARD_PERF_EN to build the saturating
// StallCount/FlushCount counters; otherwise both read as zero.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          reset,
  hazard_ctrl_if.slave  hz
);

  logic ldStall, pcPend, mulReq;
  logic mulStall, mulStart, mulBusy;
  logic stallD, flushD, flushE;

  assign hz.ForwardAE = fwdSel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA1E);
  assign hz.ForwardBE = fwdSel(hz.RegWriteM, hz.WA3M, hz.RegWriteW, hz.WA3W, hz.RA2E);

  assign ldStall = hz.MemToRegE && ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));
  assign pcPend  = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign mulReq  = hz.LongE && hz.CondExE;

  hazard_ctrl_mul_seq #(.MUL_CYCLES(MUL_CYCLES)) uMulSeq (
    .clk      (clk),
    .reset    (reset),
    .mulReq   (mulReq),
    .mulStall (mulStall),
    .mulStart (mulStart),
    .mulBusy  (mulBusy)
  );

  // While the multiplier holds Execute, the younger stages must keep their
  // contents, so flushes are suppressed and Memory receives a bubble instead.
  assign stallD = ldStall || mulStall;
  assign flushD = (pcPend || hz.PCSrcW || hz.BranchTakenE) && !mulStall;
  assign flushE = (ldStall || hz.BranchTakenE) && !mulStall;

  assign hz.StallF   = ldStall || pcPend || mulStall;
  assign hz.StallD   = stallD;
  assign hz.StallE   = mulStall;
  assign hz.FlushD   = flushD;
  assign hz.FlushE   = flushE;
  assign hz.FlushM   = mulStall;
  assign hz.MulStart = mulStart;
  assign hz.MulBusy  = mulBusy;

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stallCount, flushCount;

  // Saturating counters: stick at all-ones rather than wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stallCount <= '0;
      flushCount <= '0;
    end else begin
      if (stallD && (stallCount != '1))
        stallCount <= stallCount + 1'b1;
      if ((flushD || flushE) && (flushCount != '1))
        flushCount <= flushCount + 1'b1;
    end
  end

  assign hz.StallCount = stallCount;
  assign hz.FlushCount = flushCount;
`else
  assign hz.StallCount = '0;
  assign hz.FlushCount = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// stimulus compared against a behavioural model of the hazard rules.
// Builds with or without HAZARD_PERF_EN.
module tb_hazard_ctrl;

  localparam int MC = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CW)) hz ();

  hazard_ctrl #(.MUL_CYCLES(MC), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model state: cycles elapsed since a multiply was accepted (-1 = none),
  // and the two event tallies.
  int phase = -1;
  int sCnt = 0;
  int fCnt = 0;

  logic [1:0]    eFA, eFB;
  logic          eSF, eSD, eSE, eFD, eFE, eFM, eStart, eBusy;
  logic [CW-1:0] eSC, eFC;

  function automatic logic [1:0] fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (hz.RegWriteM && hz.WA3M == ra) return 2'b10;
    if (hz.RegWriteW && hz.WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model();
    logic ld, pc, stall;
    ld     = hz.MemToRegE && (hz.RA1D == hz.WA3E || hz.RA2D == hz.WA3E);
    pc     = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    eStart = (phase < 0) && hz.LongE && hz.CondExE;
    stall  = eStart || (phase >= 1 && phase < MC);
    eBusy  = (phase >= 1);
    eFA    = fwd(hz.RA1E);
    eFB    = fwd(hz.RA2E);
    eSF    = ld || pc || stall;
    eSD    = ld || stall;
    eSE    = stall;
    eFD    = (pc || hz.PCSrcW || hz.BranchTakenE) && !stall;
    eFE    = (ld || hz.BranchTakenE) && !stall;
    eFM    = stall;
`ifdef HAZARD_PERF_EN
    eSC = sCnt[CW-1:0];
    eFC = fCnt[CW-1:0];
`else
    eSC = '0;
    eFC = '0;
`endif
  endtask

  // One clock: update model at the rising edge, return at the falling edge.
  task automatic advance();
    model();
    @(posedge clk);
    if (!reset) begin
      phase = -1; sCnt = 0; fCnt = 0;
    end else begin
      if (eSD && sCnt < CMAX) sCnt++;
      if ((eFD || eFE) && fCnt < CMAX) fCnt++;
      if (phase >= 1) phase = (phase == MC) ? -1 : phase + 1;
      else if (eStart) phase = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    hz.RA1D = 0; hz.RA2D = 0; hz.RA1E = 0; hz.RA2E = 0;
    hz.WA3E = 0; hz.WA3M = 0; hz.WA3W = 0;
    hz.RegWriteM = 0; hz.RegWriteW = 0; hz.MemToRegE = 0;
    hz.PCSrcD = 0; hz.PCSrcE = 0; hz.PCSrcM = 0; hz.PCSrcW = 0;
    hz.BranchTakenE = 0; hz.LongE = 0; hz.CondExE = 0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b0;
    idle();
    @(negedge clk);
    #1;
    got = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
           hz.FlushD, hz.FlushE, hz.FlushM, hz.MulStart, hz.MulBusy, 4'b0};
    vectors++;
    if (got !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0000", got);
    end
    vectors++;
    if (hz.StallCount !== '0 || hz.FlushCount !== '0) begin
      miscompares++;
      $display("FAIL reset_counters got=%0d/%0d want=0/0", hz.StallCount, hz.FlushCount);
    end
    advance();
    reset = 1'b1;
    #1;
    vectors++;
    if (hz.MulBusy !== 1'b0 || hz.StallF !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release busy=%b stallF=%b want=0/0", hz.MulBusy, hz.StallF);
    end
    advance();
  endtask

  task automatic test_forwarding();
    idle();
    hz.RegWriteM = 1; hz.WA3M = 3; hz.RegWriteW = 1; hz.WA3W = 3; hz.RA1E = 3;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b10) begin
      miscompares++; $display("FAIL fwd_m_beats_w got=%b want=10", hz.ForwardAE);
    end
    hz.RegWriteM = 0;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b01) begin
      miscompares++; $display("FAIL fwd_from_w got=%b want=01", hz.ForwardAE);
    end
    hz.RA1E = 15; hz.RegWriteM = 1; hz.WA3M = 15;
    #1;
    vectors++;
    if (hz.ForwardAE !== 2'b00) begin
      miscompares++; $display("FAIL fwd_pc_never got=%b want=00", hz.ForwardAE);
    end
    idle();
    hz.RA2E = 7; hz.RegWriteW = 1; hz.WA3W = 7; hz.RegWriteM = 1; hz.WA3M = 6;
    #1;
    vectors++;
    if (hz.ForwardBE !== 2'b01 || hz.ForwardAE !== 2'b00) begin
      miscompares++;
      $display("FAIL fwd_b_from_w got=%b/%b want=01/00", hz.ForwardBE, hz.ForwardAE);
    end
    advance();
  endtask

  task automatic test_load_use();
    idle();
    hz.MemToRegE = 1; hz.WA3E = 5; hz.RA2D = 5; hz.RA1D = 2;
    #1;
    vectors++;
    if ({hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.StallE} !== 5'b11100) begin
      miscompares++;
      $display("FAIL load_use got SF/SD/FE/FD/SE=%b want=11100",
               {hz.StallF, hz.StallD, hz.FlushE, hz.FlushD, hz.StallE});
    end
    advance();
    idle();
    #1;
    vectors++;
    if ({hz.StallF, hz.StallD, hz.FlushE} !== 3'b000) begin
      miscompares++;
      $display("FAIL load_use_clear got=%b want=000", {hz.StallF, hz.StallD, hz.FlushE});
    end
    advance();
  endtask

  task automatic test_mul();
    idle();
    hz.LongE = 1; hz.CondExE = 0;
    #1;
    vectors++;
    if (hz.MulStart !== 1'b0 || hz.StallE !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_cond_fail start=%b stallE=%b want=0/0", hz.MulStart, hz.StallE);
    end
    advance();
    hz.CondExE = 1;
    for (int i = 0; i <= MC; i++) begin
      #1;
      vectors++;
      if (hz.MulStart !== (i == 0) || hz.StallE !== (i < MC) ||
          hz.FlushM !== (i < MC) || hz.MulBusy !== (i >= 1)) begin
        miscompares++;
        $display("FAIL mul_seq cyc=%0d start/stallE/flushM/busy=%b%b%b%b want=%b%b%b%b",
                 i, hz.MulStart, hz.StallE, hz.FlushM, hz.MulBusy,
                 (i == 0), (i < MC), (i < MC), (i >= 1));
      end
      advance();
    end
    idle();
    #1;
    vectors++;
    if (hz.MulBusy !== 1'b0 || hz.StallE !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_done busy=%b stallE=%b want=0/0", hz.MulBusy, hz.StallE);
    end
    advance();
  endtask

  task automatic test_reset_mid_mul();
    logic [9:0] got;
    idle();
    hz.LongE = 1; hz.CondExE = 1;
    advance();
    advance();
    #2;
    reset = 1'b0;
    idle();
    phase = -1; sCnt = 0; fCnt = 0;
    #1;
    got = {hz.StallF, hz.StallD, hz.StallE, hz.FlushD, hz.FlushE, hz.FlushM,
           hz.MulStart, hz.MulBusy, (hz.StallCount != '0), (hz.FlushCount != '0)};
    vectors++;
    if (got !== 10'b0) begin
      miscompares++;
      $display("FAIL reset_mid_mul got=%b want=0000000000", got);
    end
    advance();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if (hz.MulStart !== 1'b0 || hz.MulBusy !== 1'b0 || hz.StallE !== 1'b0) begin
        miscompares++;
        $display("FAIL no_resume cyc=%0d start/busy/stallE=%b%b%b want=000",
                 i, hz.MulStart, hz.MulBusy, hz.StallE);
      end
      advance();
    end
  endtask

  task automatic test_counters();
    idle();
    hz.MemToRegE = 1; hz.WA3E = 5; hz.RA1D = 5;
    for (int i = 0; i < 20; i++) advance();
    #1;
`ifdef HAZARD_PERF_EN
    vectors++;
    if (hz.StallCount !== 4'd15 || hz.FlushCount !== 4'd15) begin
      miscompares++;
      $display("FAIL perf_saturate got=%0d/%0d want=15/15", hz.StallCount, hz.FlushCount);
    end
    advance();
    advance();
    #1;
    vectors++;
    if (hz.StallCount !== 4'd15) begin
      miscompares++;
      $display("FAIL perf_hold got=%0d want=15", hz.StallCount);
    end
`else
    vectors++;
    if (hz.StallCount !== '0 || hz.FlushCount !== '0) begin
      miscompares++;
      $display("FAIL perf_tied_off got=%0d/%0d want=0/0", hz.StallCount, hz.FlushCount);
    end
`endif
    idle();
    advance();
  endtask

  function automatic logic [3:0] pickReg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 4'd15 : 4'(r);
  endfunction

  task automatic test_random();
    logic [23:0] got, exp;
    // Start from cleared counters so saturation is exercised again.
    reset = 1'b0;
    idle();
    advance();
    reset = 1'b1;
    for (int n = 0; n < 400; n++) begin
      hz.RA1D = pickReg(); hz.RA2D = pickReg(); hz.RA1E = pickReg(); hz.RA2E = pickReg();
      hz.WA3E = pickReg(); hz.WA3M = pickReg(); hz.WA3W = pickReg();
      hz.RegWriteM = 1'($urandom_range(0, 1));
      hz.RegWriteW = 1'($urandom_range(0, 1));
      hz.MemToRegE = ($urandom_range(0, 3) == 0);
      hz.PCSrcD = ($urandom_range(0, 7) == 0);
      hz.PCSrcE = ($urandom_range(0, 7) == 0);
      hz.PCSrcM = ($urandom_range(0, 7) == 0);
      hz.PCSrcW = ($urandom_range(0, 7) == 0);
      hz.BranchTakenE = ($urandom_range(0, 5) == 0);
      hz.LongE = ($urandom_range(0, 4) == 0);
      hz.CondExE = 1'($urandom_range(0, 1));
      #1;
      model();
      got = {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD, hz.StallE,
             hz.FlushD, hz.FlushE, hz.FlushM, hz.MulStart, hz.MulBusy,
             hz.StallCount, hz.FlushCount};
      exp = {eFA, eFB, eSF, eSD, eSE, eFD, eFE, eFM, eStart, eBusy, eSC, eFC};
      vectors++;
      if (got !== exp) begin
        miscompares++;
        $display("FAIL random cyc=%0d got=%h want=%h", n, got, exp);
      end
      advance();
    end
    idle();
    advance();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_mul();
    test_reset_mid_mul();
    test_counters();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
